// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and counter width helper for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    function automatic int MULT_CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_addshift.sv
// rtl/mult_addshift.sv - one combinational shift-and-add step of the multiplier
module mult_addshift #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   mcand,
    input  logic           lsb,
    input  logic [CW-1:0]  cnt,
    output logic [2*N-1:0] acc_next
);

    logic [2*N-1:0] partial;

    assign partial  = {{N{1'b0}}, mcand} << cnt;
    assign acc_next = lsb ? acc + partial : acc;

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - N-cycle shift-and-add multiplier with start/busy/done handshake
// MULT_SIGNED_EN adds the signed_mode port and two's-complement operand handling.
module mult_seq
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef MULT_SIGNED_EN
    input  logic           signed_mode,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = MULT_CNT_W(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mult_state_t    state;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [2*N-1:0] result;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic           sign_in;
    logic           sign_q;

`ifdef MULT_SIGNED_EN
    // Magnitudes run through the unsigned iteration; -2^(N-1) maps to 2^(N-1), which still fits.
    assign a_in    = (signed_mode && a[N-1]) ? -a : a;
    assign b_in    = (signed_mode && b[N-1]) ? -b : b;
    assign sign_in = signed_mode & (a[N-1] ^ b[N-1]);
    assign result  = sign_q ? -acc_next : acc_next;
`else
    assign a_in    = a;
    assign b_in    = b;
    assign sign_in = 1'b0;
    assign result  = acc_next;
`endif

    mult_addshift #(
        .N  (N),
        .CW (CW)
    ) u_addshift (
        .acc      (acc),
        .mcand    (mcand),
        .lsb      (mplier[0]),
        .cnt      (cnt),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_in;
                        mplier <= b_in;
                        sign_q <= sign_in;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        product <= result;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq (N=8) against an arithmetic reference
module tb_mult_seq;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           signed_mode;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_cmp;
    int n_fail;

    mult_seq #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
`ifdef MULT_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y, input logic sm);
        int sx;
        int sy;
        int p;
`ifdef MULT_SIGNED_EN
        if (sm) begin
            sx = x[N-1] ? int'(x) - (1 << N) : int'(x);
            sy = y[N-1] ? int'(y) - (1 << N) : int'(y);
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
`else
        sx = int'(x);
        sy = int'(y);
        if (sm) sx = int'(x);
`endif
        p = sx * sy;
        return p[2*N-1:0];
    endfunction

    // One operation from IDLE; optional start re-assertions at sample indices r1/r2 carrying ra/rb.
    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic sm,
                          input int r1, input int r2, input logic [N-1:0] ra, input logic [N-1:0] rb,
                          output logic [2*N-1:0] prod, output int lat, output int bcnt, output int dcnt);
        prod = '0;
        lat  = -1;
        bcnt = 0;
        dcnt = 0;
        @(negedge clk);
        a = ia;
        b = ib;
        signed_mode = sm;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clk);
            start = (k == r1) || (k == r2);
            if (start) begin
                a = ra;
                b = rb;
            end
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) begin
                    lat  = k;
                    prod = product;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [N-1:0] ia, input logic [N-1:0] ib,
                            input logic sm, input logic [2*N-1:0] want);
        logic [2*N-1:0] p;
        int lat, bc, dc;
        run_op(ia, ib, sm, -1, -1, '0, '0, p, lat, bc, dc);
        n_cmp++;
        if (p !== want) begin
            n_fail++;
            $display("FAIL %s product: got %h want %h", name, p, want);
        end
        n_cmp++;
        if (dc !== 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d want 1", name, dc);
        end
        n_cmp++;
        if (lat !== N) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, N);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [2*N-1:0] p;
        int lat, bc, dc;
        run_op(8'd13, 8'd11, 1'b0, -1, -1, '0, '0, p, lat, bc, dc);
        n_cmp++;
        if (p !== 16'd143) begin
            n_fail++;
            $display("FAIL basic product: got %0d want 143", p);
        end
        n_cmp++;
        if (lat !== N) begin
            n_fail++;
            $display("FAIL basic latency: got %0d want %0d", lat, N);
        end
        n_cmp++;
        if (bc !== N + 1) begin
            n_fail++;
            $display("FAIL basic busy_cycles: got %0d want %0d", bc, N + 1);
        end
        n_cmp++;
        if (dc !== 1) begin
            n_fail++;
            $display("FAIL basic done_count: got %0d want 1", dc);
        end
        n_cmp++;
        if (product !== 16'd143) begin
            n_fail++;
            $display("FAIL basic product_hold: got %0d want 143", product);
        end
    endtask

    task automatic test_extremes();
        check_op("ext_255x255", 8'd255, 8'd255, 1'b0, 16'hFE01);
        check_op("ext_0x200", 8'd0, 8'd200, 1'b0, 16'd0);
        check_op("ext_1x255", 8'd1, 8'd255, 1'b0, 16'd255);
        check_op("ext_128x2", 8'd128, 8'd2, 1'b0, ref_mul(8'd128, 8'd2, 1'b0));
    endtask

    task automatic test_busy_ignore();
        logic [2*N-1:0] p;
        int lat, bc, dc;
        run_op(8'd7, 8'd6, 1'b0, 2, N, 8'd9, 8'd9, p, lat, bc, dc);
        n_cmp++;
        if (p !== 16'd42) begin
            n_fail++;
            $display("FAIL busy_ignore product: got %0d want 42", p);
        end
        n_cmp++;
        if (dc !== 1) begin
            n_fail++;
            $display("FAIL busy_ignore done_count: got %0d want 1", dc);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore idle_after: got busy=%b want 0", busy);
        end
        n_cmp++;
        if (product !== 16'd42) begin
            n_fail++;
            $display("FAIL busy_ignore product_hold: got %0d want 42", product);
        end
        check_op("busy_ignore_next", 8'd9, 8'd9, 1'b0, 16'd81);
    endtask

    task automatic test_reset_midop();
        int dc;
        dc = 0;
        @(negedge clk);
        a = 8'd100;
        b = 8'd3;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dc++;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || product !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop async: got busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        n_cmp++;
        if (dc !== 0) begin
            n_fail++;
            $display("FAIL reset_midop done_count: got %0d want 0", dc);
        end
        check_op("reset_midop_fresh", 8'd5, 8'd5, 1'b0, 16'd25);
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        check_op("signed_m3x5", 8'hFD, 8'd5, 1'b1, 16'hFFF1);
        check_op("signed_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
        check_op("signed_m128x127", 8'h80, 8'd127, 1'b1, 16'hC080);
        check_op("signed_off_FDx5", 8'hFD, 8'd5, 1'b0, 16'd1265);
    endtask
`endif

    task automatic test_back_to_back();
        logic [2*N-1:0] exp_q[$];
        logic [N-1:0]   cur_a;
        logic [N-1:0]   cur_b;
        logic           cur_s;
        logic           prev_busy;
        int             accepts;
        int             results;
        int             last_acc;
        int             cyc;
        logic [2*N-1:0] want;
        accepts  = 0;
        results  = 0;
        last_acc = -1;
        cyc      = 0;
        prev_busy = busy;
        @(negedge clk);
        prev_busy = busy;
        cur_a = N'($urandom);
        cur_b = N'($urandom);
        cur_s = 1'b0;
`ifdef MULT_SIGNED_EN
        cur_s = 1'($urandom);
`endif
        a = cur_a;
        b = cur_b;
        signed_mode = cur_s;
        start = 1'b1;
        while (results < 1000 && cyc < 12000) begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) begin
                if (accepts < 1000) exp_q.push_back(ref_mul(cur_a, cur_b, cur_s));
                if (last_acc >= 0) begin
                    n_cmp++;
                    if (cyc - last_acc !== N + 2) begin
                        n_fail++;
                        $display("FAIL b2b accept_interval: got %0d want %0d", cyc - last_acc, N + 2);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            if (done) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b unexpected_done: got product %h want no result", product);
                end else begin
                    want = exp_q.pop_front();
                    if (product !== want) begin
                        n_fail++;
                        $display("FAIL b2b product[%0d]: got %h want %h", results, product, want);
                    end
                end
                results++;
            end
            prev_busy = busy;
            cur_a = N'($urandom);
            cur_b = N'($urandom);
`ifdef MULT_SIGNED_EN
            cur_s = 1'($urandom);
`endif
            a = cur_a;
            b = cur_b;
            signed_mode = cur_s;
        end
        start = 1'b0;
        n_cmp++;
        if (results !== 1000) begin
            n_fail++;
            $display("FAIL b2b result_count: got %0d want 1000 (cycle budget)", results);
        end
        repeat (N + 4) @(negedge clk);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_busy_ignore();
        test_reset_midop();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential shift-and-add multiplier. It multiplies two N-bit operands without the `*` operator and returns a 2N-bit product after a fixed N-cycle iteration, using a start/busy/done handshake. This is the generalised successor to the team's fixed-width multiplier: configurable width, a proper handshake, and optional two's-complement support. It sits on the datapath as a low-area arithmetic unit for blocks that can tolerate multi-cycle latency.

## Interface
Parameters:
- `N`, default 8: operand width in bits; legal range N ≥ 2.

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request; sampled only in IDLE.
- `a`, in, N: multiplicand; sampled on the accepting edge.
- `b`, in, N: multiplier; sampled on the accepting edge.
- `signed_mode`, in, 1: present only with `MULT_SIGNED_EN`; sampled with `a`/`b`.
- `busy`, out, 1: high while an operation is in progress.
- `done`, out, 1: single-cycle pulse when `product` becomes valid.
- `product`, out, 2N: result register.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- **IDLE:**
  - With `start`=1 at a rising edge, the block latches `a`, `b` and `signed_mode`.
  - It clears the accumulator, sets the bit counter to 0 and moves to RUN.
  - With `start`=0 it stays in IDLE.
- **RUN, once per cycle:**
  - If the current LSB of the multiplier register is 1, the block adds the multiplicand, zero-extended to 2N bits and shifted left by the count, into the 2N-bit accumulator.
  - The multiplier register shifts right by one and the counter increments.
  - After the Nth processed bit the state moves to DONE.
- **DONE:** this state lasts one cycle. `done`=1 and `product` holds the result. The next state is IDLE unconditionally.
- **Arithmetic:**
  - The accumulator is 2N bits wide, so unsigned overflow is impossible. The maximum is (2^N−1)² < 2^2N.
  - The counter is ⌈log2(N+1)⌉ bits wide.
- `start` in RUN or DONE is ignored. It is not queued, and the latched operands are unaffected.
- `product` holds its value from DONE until the next accepted `start`. At that edge it is not cleared; it updates only on the RUN→DONE transition.
- `busy`=1 in RUN and DONE, and 0 in IDLE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `product`=0, internal registers 0.
- Reset mid-operation aborts immediately and asynchronously. No `done` pulse follows, and `product` returns to 0.
- Start accepted at edge E0 means `busy`=1 after E0.
- `product` is valid and `done`=1 after edge E0+N. Latency is N cycles.
- `done` and `busy` drop after edge E0+N+1.
- Earliest next accept is edge E0+N+2, so throughput is one result per N+2 cycles.
- Operand inputs need only be stable at the accepting edge.

## Configuration
`MULT_SIGNED_EN` controls signed support.

- **Defined:**
  - The `signed_mode` port exists.
  - When `signed_mode`=1, `a` and `b` are treated as two's complement. The block latches |a| and |b| as N-bit unsigned values; |−2^(N−1)| = 2^(N−1) fits.
  - It records sign = a[N−1] XOR b[N−1] and runs the unsigned iteration.
  - On the RUN→DONE edge it writes the 2N-bit two's-complement negation if sign=1.
  - Latency is unchanged.
- **Not defined:**
  - No `signed_mode` port and no sign logic.
  - Unsigned only, with area reduced accordingly.

## Structure
- Shared package `mult_pkg` holds:
  - the `mult_state_t` enum (IDLE, RUN, DONE);
  - a `MULT_CNT_W(N)` width helper function.
- The single natural sub-module is `mult_addshift`. It is the combinational one-step datapath: accumulator, multiplicand, multiplier LSB and count in; next accumulator out.
- FSM, counter and registers stay in `mult_seq`.

## Test plan
All scenarios use N=8.

- **Basic unsigned:** a=13, b=11, start pulse → `done` exactly 8 cycles after the accept edge, `product`=143, `busy` high for 9 cycles.
- **Extremes:**
  - 255×255 → 65025 (16'hFE01).
  - 0×200 → 0.
  - 1×255 → 255.
  - Exactly one `done` pulse per operation.
- **Busy-ignore:** start 7×6, re-assert `start` with a=9, b=9 on cycles 3 and 8 (DONE) → `product`=42 and only one `done`. A later start from IDLE gives 81.
- **Reset mid-op:** start 100×3, assert `rst` at cycle 4 → immediately `busy`=0, `product`=0, no `done`. A fresh start of 5×5 → 25.
- **Signed (`MULT_SIGNED_EN`):**
  - −3×5 → 16'hFFF1.
  - −128×−128 → 16'h4000.
  - −128×127 → 16'hC080.
  - With `signed_mode`=0, 8'hFD×5 → 1265.
- **Back-to-back:** start held high continuously with a random operand stream (1000 operations) → accepts exactly every 10 cycles, each product matching the reference model.
